ps2key_ascii_fifo: RTL and testbench
====================================

PS2KEY_ASCII_FIFO -- requirements
Module: ps2key_ascii_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the FIFO depth in entries (power of two, 2..32).
REQ-002 The block SHALL have parameter AW, default 3, equal to log2(DEPTH).
REQ-003 The block SHALL have port CLOCK, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port iTrig, input, 1 bit: one-cycle pulse marking a completed make code from the PS/2 keyboard reader.
REQ-006 The block SHALL have port iData, input, 8 bits: set-2 scancode, valid while iTrig=1.
REQ-007 The block SHALL have port iState, input, 3 bits: modifier flags, [2] Shift, [1] Ctrl, [0] Alt, valid while iTrig=1.
REQ-008 The block SHALL have port iRead, input, 1 bit: consumer pop request.
REQ-009 The block SHALL have port oData, output, 8 bits: ASCII code at the FIFO head (first-word-fall-through).
REQ-010 The block SHALL have port oEmpty, output, 1 bit: FIFO holds no entries.
REQ-011 The block SHALL have port oFull, output, 1 bit: FIFO holds DEPTH entries.
REQ-012 The block SHALL have port oCount, output, AW+1 bits: number of entries held.
REQ-013 The block SHALL have port oOverflow, output, 1 bit: sticky flag, set when a character is lost to a full FIFO.

Function
REQ-014 Stage 1 SHALL register iData and iState, plus a valid bit, on every edge where iTrig=1; the valid bit clears on edges where iTrig=0.
REQ-015 Stage 2 SHALL translate the registered scancode combinationally and write the result into the FIFO on the next edge, so an entry becomes visible (oEmpty=0) at the second edge after iTrig is sampled.
REQ-016 Back-to-back iTrig pulses on consecutive cycles SHALL each be accepted without loss while the FIFO has space.
REQ-017 The translation table SHALL map letters as 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
REQ-018 The translation table SHALL map digits as 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9, 45 0; with Shift these map to ! @ # $ % ^ & * ( ) respectively.
REQ-019 The translation table SHALL map control keys as 29 space 0x20, 5A Enter 0x0D, 66 Backspace 0x08, 0D Tab 0x09, 76 Esc 0x1B, independent of Shift.
REQ-020 Shift with a letter SHALL produce the upper-case ASCII code (0x41..0x5A); without Shift, the lower-case code (0x61..0x7A).
REQ-021 Ctrl with a letter SHALL produce lower-case code AND 0x1F (a -> 0x01, z -> 0x1A); Ctrl takes priority over Shift.
REQ-022 Ctrl with a non-letter, Alt with any key, any unmapped code (including 0xE0 and 0xF0), and code 0x00 SHALL be dropped: no FIFO write and no overflow.
REQ-023 Pop SHALL occur on an edge where iRead=1 and oEmpty=0; iRead while empty SHALL be ignored with no state change.
REQ-024 A write when full without a simultaneous pop SHALL be discarded and set oOverflow=1; the FIFO contents SHALL be unchanged.
REQ-025 A write and a pop on the same edge SHALL both complete, including when full (count unchanged) and when holding one entry.
REQ-026 Read and write pointers SHALL be AW bits wide and wrap from DEPTH-1 to 0; oCount SHALL be exact for 0..DEPTH.
REQ-027 oFull SHALL equal (oCount==DEPTH) and oEmpty SHALL equal (oCount==0), both derived from registered state with no combinational path from iRead or iTrig.
REQ-028 When the FIFO is empty, oData SHALL be 0x00.

Reset
REQ-029 RESET low SHALL asynchronously clear the stage-1 valid bit, both pointers, oCount and oOverflow, giving oEmpty=1, oFull=0 and oData=0x00.
REQ-030 Reset asserted mid-operation SHALL discard both buffered and in-flight characters; the first iTrig after release SHALL be handled normally.
REQ-031 oOverflow SHALL be cleared only by reset.

Structure
REQ-032 Shared package ps2_pkg SHALL hold the scancode constants (LSHIFT 12, LCTRL 14, LALT 11, BREAK F0, EXT E0), the modifier bit indices, and the ASCII constants CR, BS, TAB, ESC.
REQ-033 The translation table SHALL be a combinational sub-module ps2_scan2ascii with inputs code[7:0] and state[2:0] and outputs ascii[7:0] and hit.

Verification
REQ-034 The bench SHALL cover: iTrig with 1C and iState=000 -> 0x61 appears at the second edge and oCount=1; iTrig with 1C and 100 -> 0x41; iTrig with 1C and 010 -> 0x01.
REQ-035 The bench SHALL cover: iTrig with 16 and 100 -> 0x21; iTrig with 5A and 000 -> 0x0D; iTrig with 1C and 001 -> no write; iTrig with E0 -> no write.
REQ-036 The bench SHALL cover: 9 consecutive iTrig pulses for 1C with no reads -> oFull=1, oCount=8, oOverflow=1, and 8 reads return 0x61 with oEmpty=1 after the eighth.
REQ-037 The bench SHALL cover: FIFO full with iRead and a valid write on the same edge -> oCount stays 8, oOverflow stays 0, and the order is preserved.
REQ-038 The bench SHALL cover: iRead while empty -> oCount stays 0 and no pointer moves; 20 write/read pairs -> pointer wrap with data intact.
REQ-039 The bench SHALL cover: RESET pulsed low with 3 entries and one in flight -> oEmpty=1, oCount=0, oOverflow=0, and the next keystroke is delivered correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 scancode constants, modifier bit positions and ASCII codes
// used by the keyboard-to-ASCII path.
package ps2_pkg;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_LCTRL  = 8'h14;
    localparam logic [7:0] SC_LALT   = 8'h11;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

    localparam int MOD_SHIFT = 2;
    localparam int MOD_CTRL  = 1;
    localparam int MOD_ALT   = 0;

    localparam logic [7:0] ASCII_NUL   = 8'h00;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_TAB   = 8'h09;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        KEY_NONE,
        KEY_LETTER,
        KEY_DIGIT,
        KEY_CTRL
    } key_class_e;

    function automatic logic [7:0] ctrl_letter(input logic [7:0] lc);
        return lc & 8'h1F;
    endfunction

    function automatic logic [7:0] upper_letter(input logic [7:0] lc);
        return lc & 8'hDF;
    endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 scancode to ASCII translation with Shift/Ctrl/Alt rules;
// hit=0 means the keystroke produces no character.
module ps2_scan2ascii
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic [2:0] state,
    output logic [7:0] ascii,
    output logic       hit
);

    key_class_e w_class;
    logic [7:0] w_base;
    logic [7:0] w_shifted;

    always_comb begin
        w_class   = KEY_NONE;
        w_base    = ASCII_NUL;
        w_shifted = ASCII_NUL;
        case (code)
            8'h1C: begin w_class = KEY_LETTER; w_base = 8'h61; end
            8'h32: begin w_class = KEY_LETTER; w_base = 8'h62; end
            8'h21: begin w_class = KEY_LETTER; w_base = 8'h63; end
            8'h23: begin w_class = KEY_LETTER; w_base = 8'h64; end
            8'h24: begin w_class = KEY_LETTER; w_base = 8'h65; end
            8'h2B: begin w_class = KEY_LETTER; w_base = 8'h66; end
            8'h34: begin w_class = KEY_LETTER; w_base = 8'h67; end
            8'h33: begin w_class = KEY_LETTER; w_base = 8'h68; end
            8'h43: begin w_class = KEY_LETTER; w_base = 8'h69; end
            8'h3B: begin w_class = KEY_LETTER; w_base = 8'h6A; end
            8'h42: begin w_class = KEY_LETTER; w_base = 8'h6B; end
            8'h4B: begin w_class = KEY_LETTER; w_base = 8'h6C; end
            8'h3A: begin w_class = KEY_LETTER; w_base = 8'h6D; end
            8'h31: begin w_class = KEY_LETTER; w_base = 8'h6E; end
            8'h44: begin w_class = KEY_LETTER; w_base = 8'h6F; end
            8'h4D: begin w_class = KEY_LETTER; w_base = 8'h70; end
            8'h15: begin w_class = KEY_LETTER; w_base = 8'h71; end
            8'h2D: begin w_class = KEY_LETTER; w_base = 8'h72; end
            8'h1B: begin w_class = KEY_LETTER; w_base = 8'h73; end
            8'h2C: begin w_class = KEY_LETTER; w_base = 8'h74; end
            8'h3C: begin w_class = KEY_LETTER; w_base = 8'h75; end
            8'h2A: begin w_class = KEY_LETTER; w_base = 8'h76; end
            8'h1D: begin w_class = KEY_LETTER; w_base = 8'h77; end
            8'h22: begin w_class = KEY_LETTER; w_base = 8'h78; end
            8'h35: begin w_class = KEY_LETTER; w_base = 8'h79; end
            8'h1A: begin w_class = KEY_LETTER; w_base = 8'h7A; end
            8'h16: begin w_class = KEY_DIGIT; w_base = 8'h31; w_shifted = 8'h21; end
            8'h1E: begin w_class = KEY_DIGIT; w_base = 8'h32; w_shifted = 8'h40; end
            8'h26: begin w_class = KEY_DIGIT; w_base = 8'h33; w_shifted = 8'h23; end
            8'h25: begin w_class = KEY_DIGIT; w_base = 8'h34; w_shifted = 8'h24; end
            8'h2E: begin w_class = KEY_DIGIT; w_base = 8'h35; w_shifted = 8'h25; end
            8'h36: begin w_class = KEY_DIGIT; w_base = 8'h36; w_shifted = 8'h5E; end
            8'h3D: begin w_class = KEY_DIGIT; w_base = 8'h37; w_shifted = 8'h26; end
            8'h3E: begin w_class = KEY_DIGIT; w_base = 8'h38; w_shifted = 8'h2A; end
            8'h46: begin w_class = KEY_DIGIT; w_base = 8'h39; w_shifted = 8'h28; end
            8'h45: begin w_class = KEY_DIGIT; w_base = 8'h30; w_shifted = 8'h29; end
            8'h29: begin w_class = KEY_CTRL; w_base = ASCII_SPACE; w_shifted = ASCII_SPACE; end
            8'h5A: begin w_class = KEY_CTRL; w_base = ASCII_CR;    w_shifted = ASCII_CR;    end
            8'h66: begin w_class = KEY_CTRL; w_base = ASCII_BS;    w_shifted = ASCII_BS;    end
            8'h0D: begin w_class = KEY_CTRL; w_base = ASCII_TAB;   w_shifted = ASCII_TAB;   end
            8'h76: begin w_class = KEY_CTRL; w_base = ASCII_ESC;   w_shifted = ASCII_ESC;   end
            // Modifier and prefix codes never reach the consumer as characters
            SC_LSHIFT, SC_LCTRL, SC_LALT, SC_BREAK, SC_EXT: w_class = KEY_NONE;
            default: w_class = KEY_NONE;
        endcase
    end

    always_comb begin
        hit   = 1'b0;
        ascii = ASCII_NUL;
        if (w_class != KEY_NONE && !state[MOD_ALT]) begin
            if (w_class == KEY_LETTER) begin
                hit = 1'b1;
                if (state[MOD_CTRL])
                    ascii = ctrl_letter(w_base);
                else if (state[MOD_SHIFT])
                    ascii = upper_letter(w_base);
                else
                    ascii = w_base;
            end else if (!state[MOD_CTRL]) begin
                hit   = 1'b1;
                ascii = state[MOD_SHIFT] ? w_shifted : w_base;
            end
        end
    end

endmodule

// File: rtl/ps2key_ascii_fifo.sv
// Keyboard make-code capture, scancode-to-ASCII translation and a
// first-word-fall-through character FIFO with sticky overflow.
module ps2key_ascii_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          iTrig,
    input  logic [7:0]    iData,
    input  logic [2:0]    iState,
    input  logic          iRead,
    output logic [7:0]    oData,
    output logic          oEmpty,
    output logic          oFull,
    output logic [AW:0]   oCount,
    output logic          oOverflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic          r_vld_p1;
    logic [7:0]    r_code_p1;
    logic [2:0]    r_state_p1;
    logic [7:0]    w_ascii_p1;
    logic          w_hit_p1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_ovf;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // Stage 1: capture the keystroke
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET)
            r_vld_p1 <= 1'b0;
        else
            r_vld_p1 <= iTrig;
    end

    always_ff @(posedge CLOCK) begin
        if (iTrig) begin
            r_code_p1  <= iData;
            r_state_p1 <= iState;
        end
    end

    // Stage 2: translate and write into the FIFO
    ps2_scan2ascii u_scan2ascii (
        .code  (r_code_p1),
        .state (r_state_p1),
        .ascii (w_ascii_p1),
        .hit   (w_hit_p1)
    );

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = iRead && !w_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts
    assign w_push  = r_vld_p1 && w_hit_p1 && (!w_full || w_pop);
    assign w_drop  = r_vld_p1 && w_hit_p1 && w_full && !w_pop;

    always_ff @(posedge CLOCK) begin
        if (w_push)
            r_mem[r_wptr] <= w_ascii_p1;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)
                r_ovf <= 1'b1;
        end
    end

    assign oData     = w_empty ? ASCII_NUL : r_mem[r_rptr];
    assign oEmpty    = w_empty;
    assign oFull     = w_full;
    assign oCount    = r_count;
    assign oOverflow = r_ovf;

endmodule

// File: tb/tb_ps2key_ascii_fifo.sv
// Bench for ps2key_ascii_fifo: directed keystroke scenarios plus a randomized
// run compared against a queue-based reference of the translation and FIFO rules.
module tb_ps2key_ascii_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b0;
    logic          iTrig = 1'b0;
    logic [7:0]    iData = 8'h00;
    logic [2:0]    iState = 3'b000;
    logic          iRead = 1'b0;
    logic [7:0]    oData;
    logic          oEmpty;
    logic          oFull;
    logic [AW:0]   oCount;
    logic          oOverflow;

    int total = 0;
    int bad   = 0;

    ps2key_ascii_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .iTrig     (iTrig),
        .iData     (iData),
        .iState    (iState),
        .iRead     (iRead),
        .oData     (oData),
        .oEmpty    (oEmpty),
        .oFull     (oFull),
        .oCount    (oCount),
        .oOverflow (oOverflow)
    );

    always #5 CLOCK = ~CLOCK;

    // Key tables in alphabet / digit-row order
    localparam logic [7:0] LET [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                        8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                        8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    localparam logic [7:0] DIG [10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
    localparam logic [7:0] DCH [10] = '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h30};
    localparam logic [7:0] DSH [10] = '{8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28,8'h29};
    localparam logic [7:0] CK  [5]  = '{8'h29,8'h5A,8'h66,8'h0D,8'h76};
    localparam logic [7:0] CA  [5]  = '{8'h20,8'h0D,8'h08,8'h09,8'h1B};

    // Directed translation cases: code, state, hit, expected character
    localparam logic [7:0] TC [11] = '{8'h1C,8'h1C,8'h1C,8'h16,8'h5A,8'h1C,8'hE0,8'h16,8'h76,8'h00,8'hF0};
    localparam logic [2:0] TS [11] = '{3'b000,3'b100,3'b010,3'b100,3'b000,3'b001,3'b000,3'b010,3'b100,3'b000,3'b000};
    localparam logic       TH [11] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
    localparam logic [7:0] TA [11] = '{8'h61,8'h41,8'h01,8'h21,8'h0D,8'h00,8'h00,8'h00,8'h1B,8'h00,8'h00};

    // Reference model state
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_pend;
    logic [7:0] m_code;
    logic [2:0] m_state;

    function automatic logic [8:0] ref_ascii(input logic [7:0] c, input logic [2:0] s);
        for (int i = 0; i < 26; i++)
            if (LET[i] == c) begin
                if (s[0]) return 9'h000;
                if (s[1]) return {1'b1, 8'(i + 1)};
                if (s[2]) return {1'b1, 8'(8'h41 + i)};
                return {1'b1, 8'(8'h61 + i)};
            end
        for (int i = 0; i < 10; i++)
            if (DIG[i] == c) begin
                if (s[0] || s[1]) return 9'h000;
                return {1'b1, s[2] ? DSH[i] : DCH[i]};
            end
        for (int i = 0; i < 5; i++)
            if (CK[i] == c) begin
                if (s[0] || s[1]) return 9'h000;
                return {1'b1, CA[i]};
            end
        return 9'h000;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_pend = 1'b0;
    endfunction

    function automatic void model_step();
        bit         pop;
        bit         full;
        logic [8:0] r;
        pop  = iRead && (mq.size() != 0);
        full = (mq.size() == DEPTH);
        if (pop) void'(mq.pop_front());
        if (m_pend) begin
            r = ref_ascii(m_code, m_state);
            if (r[8]) begin
                if (full && !pop) m_ovf = 1'b1;
                else mq.push_back(r[7:0]);
            end
        end
        m_pend  = iTrig;
        m_code  = iData;
        m_state = iState;
    endfunction

    task automatic tick();
        @(posedge CLOCK);
        model_step();
        #1;
    endtask

    task automatic pulse_reset();
        iTrig = 1'b0;
        iRead = 1'b0;
        RESET = 1'b0;
        #2;
        RESET = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_reset();
        #12;
        total++; if (oEmpty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", oEmpty); end
        total++; if (oFull !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", oFull); end
        total++; if (oCount !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", oCount); end
        total++; if (oOverflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", oOverflow); end
        total++; if (oData !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", oData); end
        RESET = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_translate();
        for (int k = 0; k < 11; k++) begin
            iTrig = 1'b1; iData = TC[k]; iState = TS[k];
            tick();
            iTrig = 1'b0;
            total++; if (oEmpty !== 1'b1) begin bad++; $display("FAIL xlate%0d_early: oEmpty got %b want 1", k, oEmpty); end
            tick();
            if (TH[k]) begin
                total++; if (oData !== TA[k]) begin bad++; $display("FAIL xlate%0d_data: got %h want %h", k, oData, TA[k]); end
                total++; if (oCount !== 4'd1) begin bad++; $display("FAIL xlate%0d_count: got %0d want 1", k, oCount); end
                iRead = 1'b1;
                tick();
                iRead = 1'b0;
            end else begin
                tick();
                total++; if (oCount !== 4'd0) begin bad++; $display("FAIL xlate%0d_drop: count got %0d want 0", k, oCount); end
                total++; if (oOverflow !== 1'b0) begin bad++; $display("FAIL xlate%0d_ovf: got %b want 0", k, oOverflow); end
            end
        end
    endtask

    task automatic test_overflow();
        pulse_reset();
        iData = 8'h1C; iState = 3'b000; iTrig = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        iTrig = 1'b0;
        tick();
        total++; if (oFull !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", oFull); end
        total++; if (oCount !== 4'd8) begin bad++; $display("FAIL ovf_count: got %0d want 8", oCount); end
        total++; if (oOverflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", oOverflow); end
        iRead = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (oData !== 8'h61) begin bad++; $display("FAIL ovf_read%0d: got %h want 61", i, oData); end
            tick();
        end
        iRead = 1'b0;
        total++; if (oEmpty !== 1'b1) begin bad++; $display("FAIL ovf_drained: oEmpty got %b want 1", oEmpty); end
        total++; if (oOverflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", oOverflow); end
    endtask

    task automatic test_full_rw();
        pulse_reset();
        total++; if (oOverflow !== 1'b0) begin bad++; $display("FAIL fullrw_ovf_cleared: got %b want 0", oOverflow); end
        iState = 3'b000;
        for (int i = 0; i < 9; i++) begin
            iTrig = 1'b1; iData = LET[i];
            tick();
        end
        iTrig = 1'b0;
        total++; if (oCount !== 4'd8) begin bad++; $display("FAIL fullrw_prefill: count got %0d want 8", oCount); end
        iRead = 1'b1;
        tick();
        iRead = 1'b0;
        total++; if (oCount !== 4'd8) begin bad++; $display("FAIL fullrw_count: got %0d want 8", oCount); end
        total++; if (oOverflow !== 1'b0) begin bad++; $display("FAIL fullrw_ovf: got %b want 0", oOverflow); end
        iRead = 1'b1;
        for (int i = 1; i < 9; i++) begin
            total++; if (oData !== 8'(8'h61 + i)) begin bad++; $display("FAIL fullrw_order%0d: got %h want %h", i, oData, 8'(8'h61 + i)); end
            tick();
        end
        iRead = 1'b0;
        total++; if (oEmpty !== 1'b1) begin bad++; $display("FAIL fullrw_empty: got %b want 1", oEmpty); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q[$];
        logic [8:0] r;
        int         sent;
        int         got;
        pulse_reset();
        iRead = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        iRead = 1'b0;
        total++; if (oCount !== 4'd0) begin bad++; $display("FAIL empty_read_count: got %0d want 0", oCount); end
        total++; if (oData !== 8'h00) begin bad++; $display("FAIL empty_read_data: got %h want 00", oData); end
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 60 && got < 20; cyc++) begin
            iTrig = (sent < 20);
            iData = LET[$urandom_range(0, 25)];
            iState = 3'($urandom_range(0, 1)) << 2;
            if (iTrig) begin
                r = ref_ascii(iData, iState);
                exp_q.push_back(r[7:0]);
                sent++;
            end
            iRead = !oEmpty;
            if (iRead) begin
                total++; if (oData !== exp_q[0]) begin bad++; $display("FAIL wrap_data%0d: got %h want %h", got, oData, exp_q[0]); end
                void'(exp_q.pop_front());
                got++;
            end
            tick();
        end
        iTrig = 1'b0; iRead = 1'b0;
        total++; if (got != 20) begin bad++; $display("FAIL wrap_pairs: got %0d want 20", got); end
        total++; if (oCount !== 4'd0) begin bad++; $display("FAIL wrap_final_count: got %0d want 0", oCount); end
    endtask

    task automatic test_reset_midway();
        pulse_reset();
        iState = 3'b000;
        for (int i = 0; i < 4; i++) begin
            iTrig = 1'b1; iData = LET[i];
            tick();
        end
        iTrig = 1'b0;
        total++; if (oCount !== 4'd3) begin bad++; $display("FAIL mid_prefill: count got %0d want 3", oCount); end
        RESET = 1'b0;
        #2;
        total++; if (oEmpty !== 1'b1) begin bad++; $display("FAIL mid_empty: got %b want 1", oEmpty); end
        total++; if (oCount !== 4'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", oCount); end
        total++; if (oOverflow !== 1'b0) begin bad++; $display("FAIL mid_ovf: got %b want 0", oOverflow); end
        total++; if (oData !== 8'h00) begin bad++; $display("FAIL mid_data: got %h want 00", oData); end
        RESET = 1'b1;
        model_reset();
        tick();
        tick();
        total++; if (oCount !== 4'd0) begin bad++; $display("FAIL mid_inflight_lost: count got %0d want 0", oCount); end
        iTrig = 1'b1; iData = 8'h1C; iState = 3'b100;
        tick();
        iTrig = 1'b0;
        tick();
        total++; if (oData !== 8'h41) begin bad++; $display("FAIL mid_next_key: got %h want 41", oData); end
        total++; if (oCount !== 4'd1) begin bad++; $display("FAIL mid_next_count: got %0d want 1", oCount); end
    endtask

    task automatic test_random();
        logic [7:0] exp_d;
        pulse_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            iTrig = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0:       iData = 8'($urandom);
                1:       iData = LET[$urandom_range(0, 25)];
                2:       iData = DIG[$urandom_range(0, 9)];
                default: iData = CK[$urandom_range(0, 4)];
            endcase
            iState = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : (3'($urandom_range(0, 1)) << 2);
            iRead  = ($urandom_range(0, 99) < ((cyc % 100) < 50 ? 15 : 70));
            tick();
            exp_d = (mq.size() != 0) ? mq[0] : 8'h00;
            total++; if (oCount !== (AW+1)'(mq.size())) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d", cyc, oCount, mq.size()); end
            total++; if (oData !== exp_d) begin bad++; $display("FAIL rnd%0d_data: got %h want %h", cyc, oData, exp_d); end
            total++; if (oEmpty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd%0d_empty: got %b want %b", cyc, oEmpty, mq.size() == 0); end
            total++; if (oFull !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rnd%0d_full: got %b want %b", cyc, oFull, mq.size() == DEPTH); end
            total++; if (oOverflow !== m_ovf) begin bad++; $display("FAIL rnd%0d_ovf: got %b want %b", cyc, oOverflow, m_ovf); end
        end
        iTrig = 1'b0; iRead = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_translate();
        test_overflow();
        test_full_rw();
        test_wrap();
        test_reset_midway();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
